// File: rtl/handshake_tx.sv
// Sending end of a 4-phase req/ack handshake; ack_in is resynchronized internally.
// Optional per-phase timeout abort is built when HANDSHAKE_TX_TIMEOUT_EN is defined.
module handshake_tx #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] dato_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic [WIDTH-1:0] dato_out,
   output logic             req_out,
   input  logic             ack_in,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

   state_e                 state;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;
   logic                   abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
      end
   end

   assign ack_s     = ack_sync[SYNC_STAGES-1];
   // A stale ack from the receiver must clear before a new word is taken.
   assign ready_out = (state == StIdle) && !ack_s;
   assign busy      = (state != StIdle);

`ifdef HANDSHAKE_TX_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

   logic [CntW-1:0] cnt;
   logic            leave;
   logic            err_q;

   assign leave = ((state == StReq) && ack_s) || ((state == StRel) && !ack_s) || abort;
   // The normal ack transition has priority over a timeout on the same cycle.
   assign abort = (cnt == CntW'(TIMEOUT_CYC - 1)) &&
                  (((state == StReq) && !ack_s) || ((state == StRel) && ack_s));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= abort;
         if ((state == StIdle) || leave) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CntW'(1);
         end
      end
   end

   assign err = err_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign abort              = 1'b0;
   assign err                = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= StIdle;
         req_out  <= 1'b0;
         dato_out <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (valid_in && ready_out) begin
                  dato_out <= dato_in;
                  req_out  <= 1'b1;
                  state    <= StReq;
               end
            end
            StReq: begin
               if (ack_s) begin
                  req_out <= 1'b0;
                  state   <= StRel;
               end else if (abort) begin
                  req_out <= 1'b0;
                  state   <= StIdle;
               end
            end
            StRel: begin
               if (!ack_s || abort) begin
                  state <= StIdle;
               end
            end
            default: begin
               req_out <= 1'b0;
               state   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/handshake_tx.md
Name: handshake_tx

Overview:
- Sending end of the 4-phase req/ack handshake that carries a data word out of the `clk` domain.
- `Synchro` brings an asynchronous level into the `clk` domain. This block is its counterpart:
  - drives a stable data word and a registered `req_out` to a receiver in another clock domain;
  - resynchronizes the returning asynchronous `ack_in` internally.
- Sits between local logic (valid/ready) and the off-domain receiver.

Parameters:
- WIDTH, 8, data word width.
- SYNC_STAGES, 2, flops in the `ack_in` synchronizer chain (minimum 2).
- TIMEOUT_CYC, 255, cycles waited per handshake phase before abort (used only with the optional feature).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- dato_in  input  WIDTH  word to send.
- valid_in  input  1  `dato_in` valid.
- ready_out  output  1  block can accept a word this cycle.
- dato_out  output  WIDTH  registered word presented to receiver.
- req_out  output  1  registered request to receiver.
- ack_in  input  1  asynchronous acknowledge from receiver.
- busy  output  1  handshake in progress (state != IDLE).
- err  output  1  one-cycle timeout pulse (constant 0 without the optional feature).

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-low; clock port `clk`, reset port `rst_n`.
- Reset values (`rst_n`=0, immediate, no clock needed):
  - `dato_out`=0, `req_out`=0, `busy`=0, `err`=0.
  - All sync flops = 0, state = IDLE, timeout counter = 0.
  - `ready_out`=1 (follows from IDLE with `ack_s`=0).
- Ack synchronizer: `ack_s` = `ack_in` delayed through SYNC_STAGES flops. The FSM uses only `ack_s`, never raw `ack_in`.
- `ready_out` is combinational: (state==IDLE) && (`ack_s`==0).
- FSM states: IDLE, REQ, REL.
  - IDLE, `valid_in` && `ready_out`:
    - capture `dato_in` into `dato_out`;
    - `req_out`<=1;
    - go to REQ.
    - `req_out` rises on the edge that accepts the word, so it is visible the cycle after acceptance.
  - REQ, `ack_s`==1: `req_out`<=0, go to REL.
  - REL, `ack_s`==0: go to IDLE. `ready_out`=1 in the following cycle.
- Data stability: `dato_out` is held constant from acceptance until the block is back in IDLE. It is not cleared after the transfer; it keeps the last word.
- Handshake round trip: at least 2*SYNC_STAGES+2 cycles for an immediately responding receiver.
- Boundary conditions:
  - `valid_in` while not ready: ignored. The source must hold it; no word is dropped or double-captured.
  - `ack_s` already high in IDLE (stale or misbehaving receiver): `ready_out` held 0 until `ack_s` falls. No new request is issued.
  - `ack_in` glitch shorter than one cycle may be missed. The receiver must hold `ack` until it sees `req` fall.
  - Back-to-back words: the next accept is possible in the first IDLE cycle. `valid_in` held high gives continuous transfers.
  - `rst_n` asserted mid-handshake: `req_out` drops immediately. After release, the block is in IDLE and waits for `ack_s`=0 before accepting.
- `busy`=1 in REQ and REL, 0 in IDLE.

Optional Feature:
- Macro: HANDSHAKE_TX_TIMEOUT_EN.
- Defined:
  - A counter (width ceil(log2(TIMEOUT_CYC+1))) clears on every state change and increments each cycle in REQ or REL.
  - When it reaches TIMEOUT_CYC without the awaited `ack_s` edge:
    - `req_out`<=0, state<=IDLE;
    - `err`=1 for exactly one cycle; counter cleared.
  - Normal `ready_out` gating then blocks new words until `ack_s`=0.
  - If `ack_s` changes in the same cycle the counter hits TIMEOUT_CYC, the normal transition wins and there is no `err`.
- Undefined:
  - No counter is built and `err` is tied to 0.
  - REQ and REL wait indefinitely.

Test Plan:
- Reset, then `valid_in`=1, `dato_in`=8'hA5; responder raises `ack` 3 cycles after seeing `req` and drops it 3 cycles after `req` falls -> `dato_out`=8'hA5 one cycle after accept and stable throughout; `req_out` 1->0 2 cycles after `ack_in` rises; `ready_out`=1 2 cycles after `ack_in` falls.
- Two words 8'h01, 8'h02 with `valid_in` held high -> exactly two handshakes, `dato_out` sequence 01 then 02, no duplicate or lost word.
- `ack_in`=1 out of reset, `valid_in`=1 -> `ready_out`=0 and `req_out`=0 until `ack_in` low, then accept within SYNC_STAGES+1 cycles.
- `rst_n` pulsed low for 5 ns while in REQ -> `req_out`=0 and `busy`=0 asynchronously; no accept until `ack_s`=0.
- With HANDSHAKE_TX_TIMEOUT_EN, TIMEOUT_CYC=10, `ack_in` never asserted -> `err` high exactly one cycle, 10 cycles after entering REQ; `req_out`=0; `ready_out`=1 next cycle.
- Without the macro, same stimulus -> `req_out` stays 1 indefinitely (checked over 1000 cycles), `err` constantly 0.
